// File: rtl/cmp_share_arb_pkg.sv
// Shared constants and helpers for the shared less-than comparator block.
package cmp_share_arb_pkg;

    localparam int CMP_W    = 32;
    localparam int MAX_NREQ = 8;

    // Requester-id width: ceil(log2(n)), never below one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp_rr_arb.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr.
module cmp_rr_arb
    import cmp_share_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_any
);

    // Walk offsets 0..NREQ-1 from rr_ptr; the first eligible index wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && elig[i] && (i == ((int'(rr_ptr) + k) % NREQ))) begin
                    grant[i]  = 1'b1;
                    grant_id  = IDW'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/comparator_32.sv
// 32-bit less-than comparator, signed or unsigned selected per operation.
module comparator_32
    import cmp_share_arb_pkg::*;
(
    input  logic [CMP_W-1:0] a,
    input  logic [CMP_W-1:0] b,
    input  logic             sign,
    output logic             lt
);

    logic signed [CMP_W:0] a_ext;
    logic signed [CMP_W:0] b_ext;

    // One extra bit lets a single signed compare serve both modes:
    // sign-extend for signed operands, zero-extend for unsigned ones.
    always_comb begin
        a_ext = $signed({sign & a[CMP_W-1], a});
        b_ext = $signed({sign & b[CMP_W-1], b});
        lt    = (a_ext < b_ext);
    end

endmodule

// File: rtl/cmp_share_arb.sv
// Shares one comparator_32 among NREQ requesters: round-robin issue into a
// registered operand stage, result lands in a per-requester response register.
module cmp_share_arb
    import cmp_share_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*CMP_W-1:0] req_src1,
    input  logic [NREQ*CMP_W-1:0] req_src2,
    input  logic [NREQ-1:0]       req_sign,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [NREQ-1:0]       resp_res
);

    logic [NREQ-1:0]  busy_p1;
    logic [NREQ-1:0]  elig_p0;
    logic [NREQ-1:0]  grant_p0;
    logic [IDW-1:0]   grant_id_p0;
    logic             grant_any_p0;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_next;
    logic [CMP_W-1:0] src1_p0;
    logic [CMP_W-1:0] src2_p0;
    logic             sign_p0;

    logic             vld_p1;
    logic [IDW-1:0]   id_p1;
    logic [CMP_W-1:0] src1_p1;
    logic [CMP_W-1:0] src2_p1;
    logic             sign_p1;
    logic             lt_p1;

    // Eligibility: a requester with an op in flight or an unconsumed result
    // is held off, which is what keeps response set and clear from colliding.
    always_comb begin
        busy_p1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            busy_p1[i] = vld_p1 && (int'(id_p1) == i);
        end
        elig_p0 = req_valid & ~busy_p1 & ~resp_valid & {NREQ{~(flush | reset)}};
    end

    cmp_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .elig      (elig_p0),
        .rr_ptr    (rr_ptr),
        .grant     (grant_p0),
        .grant_id  (grant_id_p0),
        .grant_any (grant_any_p0)
    );

    assign req_ready = grant_p0;
    assign rr_next   = (int'(grant_id_p0) == NREQ - 1) ? '0 : grant_id_p0 + 1'b1;

    // Operand mux for the granted requester.
    always_comb begin
        src1_p0 = '0;
        src2_p0 = '0;
        sign_p0 = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_p0[i]) begin
                src1_p0 = req_src1[CMP_W*i +: CMP_W];
                src2_p0 = req_src2[CMP_W*i +: CMP_W];
                sign_p0 = req_sign[i];
            end
        end
    end

    // ---- stage p0 -> p1: issue control (valid, round-robin pointer) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            rr_ptr <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= grant_any_p0;
            if (grant_any_p0) begin
                rr_ptr <= rr_next;
            end
        end
    end

    // Operand registers only load on a grant; vld_p1 qualifies them.
    always_ff @(posedge clk) begin
        if (grant_any_p0) begin
            id_p1   <= grant_id_p0;
            src1_p1 <= src1_p0;
            src2_p1 <= src2_p0;
            sign_p1 <= sign_p0;
        end
    end

    comparator_32 u_cmp (
        .a    (src1_p1),
        .b    (src2_p1),
        .sign (sign_p1),
        .lt   (lt_p1)
    );

    // ---- stage p1 -> p2: per-requester response registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= '0;
            resp_res   <= '0;
        end else if (flush) begin
            resp_valid <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
                if (busy_p1[i]) begin
                    resp_valid[i] <= 1'b1;
                    resp_res[i]   <= lt_p1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmp_share_arb.sv
// Self-checking bench for cmp_share_arb (NREQ=2) with a response scoreboard.
module tb_cmp_share_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_src1;
    logic [NREQ*32-1:0] req_src2;
    logic [NREQ-1:0]   req_sign;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [NREQ-1:0]   resp_res;

    int checks   = 0;
    int failures = 0;

    bit exp_q0[$];
    bit exp_q1[$];
    bit mon_have;
    bit mon_exp;

    cmp_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_sign   (req_sign),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_res   (resp_res)
    );

    always #5 clk = ~clk;

    // Reference: signed compare done by flipping the MSBs and comparing unsigned.
    function automatic bit model_lt(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ab;
        logic [31:0] bb;
        ab = s ? (a ^ 32'h8000_0000) : a;
        bb = s ? (b ^ 32'h8000_0000) : b;
        return (ab < bb);
    endfunction

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        if (reset === 1'b1 || flush === 1'b1) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (resp_valid[i] === 1'b1 && resp_ready[i] === 1'b1) begin
                    mon_have = 1'b0;
                    mon_exp  = 1'b0;
                    if (i == 0 && exp_q0.size() > 0) begin mon_exp = exp_q0.pop_front(); mon_have = 1'b1; end
                    if (i == 1 && exp_q1.size() > 0) begin mon_exp = exp_q1.pop_front(); mon_have = 1'b1; end
                    checks++;
                    if (!mon_have) begin
                        failures++;
                        $display("FAIL sb_unexpected_resp req%0d got resp_res=%b, required no response", i, resp_res[i]);
                    end else if (resp_res[i] !== mon_exp) begin
                        failures++;
                        $display("FAIL sb_resp_res req%0d got %b required %b", i, resp_res[i], mon_exp);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) begin
                    if (i == 0) exp_q0.push_back(model_lt(req_src1[32*i +: 32], req_src2[32*i +: 32], req_sign[i]));
                    else        exp_q1.push_back(model_lt(req_src1[32*i +: 32], req_src2[32*i +: 32], req_sign[i]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; req_valid = 2'b11; resp_ready = 2'b11;
        req_src1 = '0; req_src2 = {32'd5, 32'd5}; req_sign = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got %b required 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got %b required 00", resp_valid); end
        checks++; if (resp_res !== 2'b00) begin failures++; $display("FAIL reset_resp_res got %b required 00", resp_res); end
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL post_reset_resp_valid got %b required 00", resp_valid); end
    endtask

    task automatic test_lone();
        for (int s = 1; s >= 0; s--) begin
            @(posedge clk); #1;
            req_src1[31:0] = 32'hFFFF_FFFF; req_src2[31:0] = 32'h0000_0001;
            req_sign[0] = s[0]; req_valid = 2'b01;
            @(negedge clk);
            checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL lone_ready sign=%0d got %b required 01", s, req_ready); end
            @(posedge clk); #1;
            req_valid = 2'b00;
            @(negedge clk);
            checks++; if (resp_valid[0] !== 1'b0) begin failures++; $display("FAIL lone_early_resp sign=%0d got %b required 0", s, resp_valid[0]); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (resp_valid[0] !== 1'b1) begin failures++; $display("FAIL lone_resp_valid sign=%0d got %b required 1", s, resp_valid[0]); end
            checks++; if (resp_res[0] !== s[0]) begin failures++; $display("FAIL lone_resp_res sign=%0d got %b required %b", s, resp_res[0], s[0]); end
        end
    endtask

    task automatic test_round_robin();
        // Lone req1 first so the pointer wraps back to 0.
        @(posedge clk); #1;
        req_src1[63:32] = 32'd7; req_src2[63:32] = 32'd9; req_sign[1] = 1'b0; req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_lone1_ready got %b required 10", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        req_src1[31:0] = 32'd1; req_src2[31:0] = 32'd2; req_sign[0] = 1'b0;
        req_src1[63:32] = 32'd2; req_src2[63:32] = 32'd1; req_sign[1] = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_first_grant got %b required 01", req_ready); end
        @(posedge clk); #1; req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_second_grant got %b required 10", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b01) begin failures++; $display("FAIL rr_resp_t2 got %b required 01", resp_valid); end
        checks++; if (resp_res[0] !== 1'b1) begin failures++; $display("FAIL rr_res0 got %b required 1", resp_res[0]); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b10) begin failures++; $display("FAIL rr_resp_t3 got %b required 10", resp_valid); end
        checks++; if (resp_res[1] !== 1'b0) begin failures++; $display("FAIL rr_res1 got %b required 0", resp_res[1]); end
        @(posedge clk); #1; req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rr_ptr_wrapped got %b required 01", req_ready); end
        @(posedge clk); #1; req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rr_again_req1 got %b required 10", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_backpressure();
        int g1;
        logic hs1;
        g1 = 0;
        #1;
        resp_ready = 2'b10;
        req_src1[31:0] = 32'hFFFF_0000; req_src2[31:0] = 32'h0000_0010; req_sign[0] = 1'b1;
        req_src1[63:32] = $urandom(); req_src2[63:32] = $urandom(); req_sign[1] = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_first_grant got %b required 01", req_ready); end
        hs1 = req_valid[1] & req_ready[1];
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (hs1) begin
                req_src1[63:32] = $urandom(); req_src2[63:32] = $urandom(); req_sign[1] = $urandom_range(0, 1);
            end
            @(negedge clk);
            hs1 = req_valid[1] & req_ready[1];
            if (c >= 2) begin
                if (hs1) g1++;
                checks++; if (resp_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got %b required 1", c, resp_valid[0]); end
                checks++; if (resp_res[0] !== 1'b1) begin failures++; $display("FAIL bp_hold_res cyc=%0d got %b required 1", c, resp_res[0]); end
                checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_req0_blocked cyc=%0d got %b required 0", c, req_ready[0]); end
            end
        end
        checks++; if (g1 != 2) begin failures++; $display("FAIL bp_req1_rate got %0d grants in 6 cycles required 2", g1); end
        @(posedge clk); #1;
        req_valid = 2'b00; resp_ready = 2'b11;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] a;
        logic [31:0] b;
        #1;
        req_src1[63:32] = 32'h0000_0001; req_src2[63:32] = 32'h0000_0002; req_sign[1] = 1'b0;
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL flush_pre_grant got %b required 10", req_ready); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL flush_no_grant got %b required 00", req_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        a = 32'h8000_0001; b = 32'h0000_0003;
        req_src1[63:32] = a; req_src2[63:32] = b; req_sign[1] = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL flush_regrant got %b required 10", req_ready); end
        checks++; if (resp_valid[1] !== 1'b0) begin failures++; $display("FAIL flush_dropped_t2 got %b required 0", resp_valid[1]); end
        @(posedge clk); #1; req_valid = 2'b00;
        @(negedge clk);
        checks++; if (resp_valid[1] !== 1'b0) begin failures++; $display("FAIL flush_dropped_t3 got %b required 0", resp_valid[1]); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (resp_valid[1] !== 1'b1) begin failures++; $display("FAIL flush_new_resp got %b required 1", resp_valid[1]); end
        checks++; if (resp_res[1] !== 1'b1) begin failures++; $display("FAIL flush_new_res got %b required 1", resp_res[1]); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_midop();
        #1;
        resp_ready = 2'b00;
        req_src1 = {32'd3, 32'd1}; req_src2 = {32'd4, 32'd2}; req_sign = 2'b00;
        req_valid = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_mid_g0 got %b required 01", req_ready); end
        @(posedge clk); #1; req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rst_mid_g1 got %b required 10", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00; reset = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b01) begin failures++; $display("FAIL rst_mid_precond got %b required 01", resp_valid); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL rst_mid_resp_valid got %b required 00", resp_valid); end
        checks++; if (resp_res !== 2'b00) begin failures++; $display("FAIL rst_mid_resp_res got %b required 00", resp_res); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_mid_req_ready got %b required 00", req_ready); end
        // Move the pointer to 1, then reset again and confirm it returns to 0.
        @(posedge clk); #1; resp_ready = 2'b11; req_valid = 2'b01;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_ptr_setup got %b required 01", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_ptr_zero got %b required 01", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL rst_no_stale got %b required 00", resp_valid); end
        @(posedge clk); #1; req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rst_post_g1 got %b required 10", req_ready); end
        @(posedge clk); #1; req_valid = 2'b00;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_boundary();
        logic [31:0] ta [7] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005};
        logic [31:0] tb [7] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0005};
        logic        ts [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        te [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            req_src1[31:0] = ta[k]; req_src2[31:0] = tb[k]; req_sign[0] = ts[k]; req_valid = 2'b01;
            @(negedge clk);
            @(posedge clk); #1; req_valid = 2'b00;
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (resp_valid[0] !== 1'b1 || resp_res[0] !== te[k]) begin
                failures++;
                $display("FAIL boundary_%0d got valid=%b res=%b required valid=1 res=%b", k, resp_valid[0], resp_res[0], te[k]);
            end
        end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] hs;
        hs = '0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            resp_ready = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_src1[32*i +: 32] = $urandom();
                    req_src2[32*i +: 32] = ($urandom_range(0, 4) == 0) ? req_src1[32*i +: 32] : $urandom();
                    req_sign[i] = $urandom_range(0, 1);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            hs = req_valid & req_ready;
            checks++;
            if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0)) begin
                failures++;
                $display("FAIL b2b_ready_shape cyc=%0d got req_ready=%b req_valid=%b required onehot0 subset", c, req_ready, req_valid);
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00; resp_ready = 2'b11;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (exp_q0.size() != 0) begin failures++; $display("FAIL sb_drain_req0 got %0d pending required 0", exp_q0.size()); end
        checks++; if (exp_q1.size() != 0) begin failures++; $display("FAIL sb_drain_req1 got %0d pending required 0", exp_q1.size()); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0; resp_ready = '1;
        req_src1 = '0; req_src2 = '0; req_sign = '0;
        test_reset();
        test_lone();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_boundary();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
